ddc_out_fifo: RTL and testbench
===============================

DDC_OUT_FIFO -- requirements
Module: ddc_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `M_O_3_DDC+`N_O_3_DDC, width of one decimated DDC output sample.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries; power of two, at least 4.
REQ-003 SHALL have parameter AFULL_THRESH, default 12, level at or above which almost_full_out asserts.
REQ-004 SHALL have ports clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port src_data_in, input, DATA_WIDTH: sample from the DDC output stage.
REQ-007 SHALL have port src_valid_in, input, 1: src_data_in valid this cycle; the upstream never stalls.
REQ-008 SHALL have port src_ready_out, output, 1: status only, equal to !full.
REQ-009 SHALL have port dst_data_out, output, DATA_WIDTH: head-of-FIFO sample.
REQ-010 SHALL have port dst_valid_out, output, 1: dst_data_out valid, equal to !empty.
REQ-011 SHALL have port dst_ready_in, input, 1: downstream accepts dst_data_out.
REQ-012 SHALL have port level_out, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 SHALL have port almost_full_out, output, 1: level_out >= AFULL_THRESH.
REQ-014 SHALL have port overflow_out, output, 1: sticky flag, set when a sample is dropped.
REQ-015 SHALL have port clear_ovf_in, input, 1: clears overflow_out.
REQ-016 SHALL have port drop_cnt_out, output, 16: count of dropped samples (see Configuration).

Function
REQ-017 SHALL be first-word-fall-through: a sample pushed into an empty FIFO in cycle N SHALL appear on dst_data_out with dst_valid_out=1 in cycle N+1.
REQ-018 SHALL pop when dst_valid_out && dst_ready_in; dst_data_out SHALL hold stable while dst_valid_out=1 and dst_ready_in=0.
REQ-019 SHALL push when src_valid_in && (!full || pop in the same cycle).
REQ-020 SHALL leave level unchanged on a simultaneous push and pop, at any level including 0 and DEPTH.
REQ-021 SHALL discard a sample and leave contents unchanged when src_valid_in=1 while full and no pop occurs.
REQ-022 SHALL wrap the read/write pointers modulo DEPTH, with full/empty distinguished by an extra pointer MSB.
REQ-023 SHALL set overflow_out in the cycle after a drop; clear_ovf_in clears it in the next cycle; if a drop and clear_ovf_in coincide, set SHALL win.
REQ-024 SHALL register level_out, almost_full_out and overflow_out, all updated the cycle after the causing event.
REQ-025 SHALL never alter sample data: bit-exact pass-through, order preserved.

Reset
REQ-026 SHALL, with rst=1 at a clock edge: empty the FIFO, level_out=0, dst_valid_out=0, src_ready_out=1, almost_full_out=0, overflow_out=0, drop_cnt_out=0.
REQ-027 SHALL discard stored data when reset is applied mid-stream; no push or pop is performed in a reset cycle.
REQ-028 SHALL leave dst_data_out content don't-care while dst_valid_out=0.

Configuration
REQ-029 SHALL implement a 16-bit drop counter when macro DDC_FIFO_DROP_CNT_EN is defined: +1 per dropped sample, saturating at 0xFFFF, cleared by clear_ovf_in unless a drop occurs in the same cycle, in which case it becomes 1.
REQ-030 SHALL tie drop_cnt_out to 0 and omit the counter logic when DDC_FIFO_DROP_CNT_EN is undefined; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: reset, then push 0x1234 in cycle 0 with dst_ready_in=1 -> dst_valid_out=1 with 0x1234 in cycle 1; level_out back to 0 in cycle 2.
REQ-032 SHALL cover: dst_ready_in=0, push 16 samples 1..16 -> level_out=16, src_ready_out=0, almost_full_out=1 from the 12th push; then drain -> samples 1..16 in order.
REQ-033 SHALL cover: full FIFO, push 3 more samples with no pop -> overflow_out=1, contents unchanged, drop_cnt_out=3 (macro on) or 0 (macro off).
REQ-034 SHALL cover: full FIFO, push and pop in the same cycle for 20 cycles -> level_out stays 16, no drop, output order intact across pointer wrap.
REQ-035 SHALL cover: drop and clear_ovf_in in the same cycle -> overflow_out=1; with the macro on, drop_cnt_out=1.
REQ-036 SHALL cover: rst asserted with level 7 -> next cycle level_out=0, dst_valid_out=0, overflow_out=0.

Source files
------------

// File: rtl/ddc_out_fifo.sv
// ddc_out_fifo: first-word-fall-through output FIFO for decimated DDC samples.
// The upstream never stalls, so samples that arrive while full are dropped and
// flagged on a sticky overflow bit.
// Optional build macro DDC_FIFO_DROP_CNT_EN adds a saturating 16-bit drop counter;
// without it drop_cnt_out is tied to zero.

`ifndef M_O_3_DDC
`define M_O_3_DDC 8
`endif
`ifndef N_O_3_DDC
`define N_O_3_DDC 8
`endif

module ddc_out_fifo #(
  parameter int unsigned DATA_WIDTH   = `M_O_3_DDC + `N_O_3_DDC,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    src_data_in,
  input  logic                     src_valid_in,
  output logic                     src_ready_out,
  output logic [DATA_WIDTH-1:0]    dst_data_out,
  output logic                     dst_valid_out,
  input  logic                     dst_ready_in,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     almost_full_out,
  output logic                     overflow_out,
  input  logic                     clear_ovf_in,
  output logic [15:0]              drop_cnt_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  logic [PtrW:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic full, empty, push, pop, drop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop  = !empty && dst_ready_in;
  assign push = src_valid_in && (!full || pop);
  assign drop = src_valid_in && full && !pop;

  assign src_ready_out   = !full;
  assign dst_valid_out   = !empty;
  assign dst_data_out    = mem_q[rptr_q[PtrW-1:0]];
  assign level_out       = level_q;
  assign almost_full_out = afull_q;
  assign overflow_out    = ovf_q;

  // Next-state for pointers, occupancy and status flags.
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    afull_d = (32'(level_d) >= AFULL_THRESH);
    // Set wins over clear when both happen in one cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf_in) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state; reset discards all stored samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sample storage; no reset needed since contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q[PtrW-1:0]] <= src_data_in;
    end
  end

`ifdef DDC_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf_in) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_out = drop_cnt_q;
`else
  assign drop_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_ddc_out_fifo.sv
// Directed + randomised bench for ddc_out_fifo with a queue scoreboard.
module tb_ddc_out_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_data_in;
  logic        src_valid_in;
  logic        src_ready_out;
  logic [15:0] dst_data_out;
  logic        dst_valid_out;
  logic        dst_ready_in;
  logic [4:0]  level_out;
  logic        almost_full_out;
  logic        overflow_out;
  logic        clear_ovf_in;
  logic [15:0] drop_cnt_out;

  ddc_out_fifo #(
    .DATA_WIDTH   (16),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_data_in     (src_data_in),
    .src_valid_in    (src_valid_in),
    .src_ready_out   (src_ready_out),
    .dst_data_out    (dst_data_out),
    .dst_valid_out   (dst_valid_out),
    .dst_ready_in    (dst_ready_in),
    .level_out       (level_out),
    .almost_full_out (almost_full_out),
    .overflow_out    (overflow_out),
    .clear_ovf_in    (clear_ovf_in),
    .drop_cnt_out    (drop_cnt_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] sb[$];
  logic        ovf_m = 1'b0;
  logic [15:0] cnt_m = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_status();
    chk("level", 32'(level_out), 32'(sb.size()));
    chk("almost_full", 32'(almost_full_out), 32'(sb.size() >= AFULL));
    chk("src_ready", 32'(src_ready_out), 32'(sb.size() != DEPTH));
    chk("overflow", 32'(overflow_out), 32'(ovf_m));
    chk("drop_cnt", 32'(drop_cnt_out), 32'(cnt_m));
  endtask

  // One clock cycle: drive inputs, score the pop, predict, advance, check status.
  task automatic cycle(input logic v, input logic [15:0] d, input logic r, input logic c);
    logic m_full, m_pop, m_push, m_drop;
    src_valid_in = v;
    src_data_in  = d;
    dst_ready_in = r;
    clear_ovf_in = c;
    m_full = (sb.size() == DEPTH);
    m_pop  = (sb.size() != 0) && r;
    chk("dst_valid", 32'(dst_valid_out), 32'(sb.size() != 0));
    if (m_pop) begin
      chk("dst_data", 32'(dst_data_out), 32'(sb[0]));
      void'(sb.pop_front());
    end
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !m_pop;
    if (m_push) sb.push_back(d);
    if (m_drop) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
`ifdef DDC_FIFO_DROP_CNT_EN
    if (c) cnt_m = m_drop ? 16'd1 : 16'd0;
    else if (m_drop && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
    @(posedge clk);
    #1;
    chk_status();
  endtask

  // Reset with live traffic on the inputs; nothing may be pushed or popped.
  task automatic do_reset();
    rst          = 1'b1;
    src_valid_in = 1'b1;
    src_data_in  = 16'hDEAD;
    dst_ready_in = 1'b1;
    clear_ovf_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    cnt_m = 16'h0;
    chk("rst_valid", 32'(dst_valid_out), 32'd0);
    chk_status();
  endtask

  initial begin
    rst          = 1'b1;
    src_valid_in = 1'b0;
    src_data_in  = 16'h0;
    dst_ready_in = 1'b0;
    clear_ovf_in = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fall-through latency and immediate drain.
    cycle(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("fwft_valid", 32'(dst_valid_out), 32'd1);
    chk("fwft_data", 32'(dst_data_out), 32'h1234);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fwft_level0", 32'(level_out), 32'd0);

    // Fill with 1..16, no pops.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 12) chk("afull_at_12", 32'(almost_full_out), 32'd1);
      if (i == 11) chk("afull_at_11", 32'(almost_full_out), 32'd0);
    end
    chk("full_level", 32'(level_out), 32'd16);
    chk("full_ready", 32'(src_ready_out), 32'd0);

    // Three drops while full.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hA0 + 16'(i), 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow_out), 32'd1);
    chk("head_kept", 32'(dst_data_out), 32'd1);
`ifdef DDC_FIFO_DROP_CNT_EN
    chk("drop3", 32'(drop_cnt_out), 32'd3);
`else
    chk("drop3", 32'(drop_cnt_out), 32'd0);
`endif

    // Push and pop together while full, across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'h100 + 16'(i), 1'b1, 1'b0);
      chk("wrap_level", 32'(level_out), 32'd16);
    end

    // Clear, then drop coinciding with clear.
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow_out), 32'd0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow_out), 32'd1);
`ifdef DDC_FIFO_DROP_CNT_EN
    chk("drop_clr_one", 32'(drop_cnt_out), 32'd1);
`else
    chk("drop_clr_one", 32'(drop_cnt_out), 32'd0);
`endif

    // Drain to level 7, then reset mid-stream.
    for (int i = 0; i < 9; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("level7", 32'(level_out), 32'd7);
    do_reset();
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("final_empty", 32'(dst_valid_out), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
